card_deck: RTL

Dealer-side deck source for the blackjack game. Holds a 52-card deck as a used-card mask and deals one unrepeated pseudo-random card per request. Dealing uses a free-running LFSR with linear probing. The block sits directly upstream of `blackjack_FSM`, which issues `draw_req` and consumes the card value and rank/suit used by `card` for drawing.

---
 rtl/card_deck_if.sv | 45 ++++
 rtl/card_deck.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/card_deck_if.sv
// ---------------------------------------------------------------------------
// card_deck_if
// Groups the request/deal signals between the blackjack game FSM and the
// dealer-side deck source.
//
// Signals:
//   shuffle     requester -> deck  single-cycle pulse, return all cards
//   draw_req    requester -> deck  single-cycle pulse, request one card
//   card_valid  deck -> requester  single-cycle pulse, card outputs valid
//   card_rank   deck -> requester  1=A, 2..10, 11=J, 12=Q, 13=K
//   card_suit   deck -> requester  0..3
//   card_value  deck -> requester  blackjack value (A=11, J/Q/K=10)
//   cards_left  deck -> requester  cards remaining, 0..52
//   deck_empty  deck -> requester  cards_left == 0
//   low_deck    deck -> requester  cards_left at or below threshold
//   busy        deck -> requester  searching or clearing
//   draw_err    deck -> requester  single-cycle pulse, draw on empty deck
//
// Modports: master = game FSM (requester), slave = card_deck.
// ---------------------------------------------------------------------------
interface card_deck_if;
    logic       shuffle;
    logic       draw_req;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [4:0] card_value;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       low_deck;
    logic       busy;
    logic       draw_err;

    modport master (
        output shuffle, draw_req,
        input  card_valid, card_rank, card_suit, card_value,
        input  cards_left, deck_empty, low_deck, busy, draw_err
    );

    modport slave (
        input  shuffle, draw_req,
        output card_valid, card_rank, card_suit, card_value,
        output cards_left, deck_empty, low_deck, busy, draw_err
    );
endinterface

// File: rtl/card_deck.sv
// ---------------------------------------------------------------------------
// card_deck
// Dealer-side 52-card deck. Tracks dealt cards in a used mask and deals one
// unrepeated card per request. The search start point comes from a
// free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); collisions are
// resolved by linear probing, one slot per cycle, wrapping 51 -> 0.
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   card_deck_if.slave (shuffle/draw_req in, card + status out)
//
// Parameters:
//   LFSR_SEED   LFSR reset value, must be non-zero
//   LOW_THRESH  low_deck asserts when cards_left <= LOW_THRESH
//
// Build option:
//   CARD_DECK_SEQ_EN  when defined, every search starts at index 0 so a
//                     fresh deck deals in ascending order 0..51.
// ---------------------------------------------------------------------------
module card_deck #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          LOW_THRESH = 15
) (
    input  logic        clk,
    input  logic        rst,
    card_deck_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    localparam logic [5:0] LOW_T     = 6'(LOW_THRESH);
    localparam logic [5:0] FULL_DECK = 6'd52;

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [51:0] used;
    logic [5:0]  ptr;
    logic [5:0]  left_q;
    logic [5:0]  left_dec;
    logic        empty_q;
    logic        low_q;
    logic        err_q;
    logic [3:0]  rank_q;
    logic [1:0]  suit_q;
    logic [4:0]  value_q;
    logic [5:0]  start_ptr;
    logic [1:0]  ptr_suit;
    logic [5:0]  ptr_base;
    logic [3:0]  ptr_rank;
    logic [4:0]  ptr_value;

    // The LFSR runs every cycle regardless of FSM activity so the deal
    // start point depends on when the player asks, not just on how many
    // cards have been dealt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Search start point. The 6-bit LFSR slice covers 0..63, so the
    // 52..63 overflow folds back onto 0..11.
`ifdef CARD_DECK_SEQ_EN
    assign start_ptr = 6'd0;
`else
    assign start_ptr = (lfsr[5:0] >= FULL_DECK) ? (lfsr[5:0] - FULL_DECK) : lfsr[5:0];
`endif

    // Decode the probed index into suit / rank / blackjack value. Suit is
    // found by range compare to avoid a divider.
    always_comb begin
        ptr_suit = 2'd0;
        ptr_base = 6'd0;
        if (ptr >= 6'd39) begin
            ptr_suit = 2'd3;
            ptr_base = 6'd39;
        end else if (ptr >= 6'd26) begin
            ptr_suit = 2'd2;
            ptr_base = 6'd26;
        end else if (ptr >= 6'd13) begin
            ptr_suit = 2'd1;
            ptr_base = 6'd13;
        end
        ptr_rank = 4'(ptr - ptr_base) + 4'd1;
        if (ptr_rank == 4'd1) begin
            ptr_value = 5'd11;
        end else if (ptr_rank > 4'd10) begin
            ptr_value = 5'd10;
        end else begin
            ptr_value = {1'b0, ptr_rank};
        end
    end

    assign left_dec = left_q - 6'd1;

    // Main deal FSM. Status flags are registered together with the count
    // so they change in the same cycle as card_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            used    <= '0;
            ptr     <= 6'd0;
            left_q  <= FULL_DECK;
            empty_q <= 1'b0;
            low_q   <= 1'b0;
            err_q   <= 1'b0;
            rank_q  <= 4'd0;
            suit_q  <= 2'd0;
            value_q <= 5'd0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.shuffle) begin
                        state <= ST_CLEAR;
                    end else if (bus.draw_req) begin
                        if (left_q != 6'd0) begin
                            ptr   <= start_ptr;
                            state <= ST_SEARCH;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SEARCH: begin
                    // A shuffle abandons the search without touching the mask.
                    if (bus.shuffle) begin
                        state <= ST_CLEAR;
                    end else if (!used[ptr]) begin
                        used[ptr] <= 1'b1;
                        left_q    <= left_dec;
                        empty_q   <= (left_dec == 6'd0);
                        low_q     <= (left_dec <= LOW_T);
                        rank_q    <= ptr_rank;
                        suit_q    <= ptr_suit;
                        value_q   <= ptr_value;
                        state     <= ST_OUT;
                    end else begin
                        ptr <= (ptr == 6'd51) ? 6'd0 : (ptr + 6'd1);
                    end
                end
                ST_OUT: begin
                    state <= bus.shuffle ? ST_CLEAR : ST_IDLE;
                end
                ST_CLEAR: begin
                    used    <= '0;
                    left_q  <= FULL_DECK;
                    empty_q <= 1'b0;
                    low_q   <= (FULL_DECK <= LOW_T);
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.card_valid = (state == ST_OUT);
    assign bus.busy       = (state == ST_SEARCH) || (state == ST_CLEAR);
    assign bus.card_rank  = rank_q;
    assign bus.card_suit  = suit_q;
    assign bus.card_value = value_q;
    assign bus.cards_left = left_q;
    assign bus.deck_empty = empty_q;
    assign bus.low_deck   = low_q;
    assign bus.draw_err   = err_q;

endmodule
